// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: decodes op/funct through a state machine and drives the
// datapath enables, mux selects and ALU operation code each cycle.
module multicycle_control_fsm #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] ALUControl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q, state_d;
  logic       funct_ok;
  logic [2:0] r_alu;
  logic       pcwrite, branch;

  always_comb begin
    funct_ok = 1'b1;
    r_alu    = 3'b000;
    case (funct)
      6'b100000: r_alu = 3'b000;
      6'b100010: r_alu = 3'b001;
      6'b100100: r_alu = 3'b010;
      6'b100101: r_alu = 3'b011;
      6'b101010: r_alu = 3'b101;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    ALUControl = 3'b000;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        pcwrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     if (funct_ok) state_d = S_EXECUTE;
                        else          illegal = 1'b1;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      illegal = 1'b1;
        endcase
        if (illegal) state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = r_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b001;
        PCSrc      = 2'b01;
        branch     = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = 2'b10;
        pcwrite = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    PCEn      = pcwrite | (branch & zero);
    state_dbg = state_q;
    // Reset wins over everything so an abandoned instruction can never write.
    if (reset) begin
      ALUControl = 3'b000;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCSrc      = 2'b00;
      PCEn       = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      illegal    = 1'b0;
      state_dbg  = 4'd0;
    end
  end

endmodule
